mem_uart_bridge: RTL and testbench

MEM_UART_BRIDGE -- requirements
Module: mem_uart_bridge

---
 rtl/mem_uart_bridge_pkg.sv | 23 ++
 rtl/mem_uart_bridge_if.sv | 12 +
 rtl/mem_uart_bridge_uart_rx.sv | 105 ++++++++++
 rtl/mem_uart_bridge.sv | 154 +++++++++++++++
 tb/tb_mem_uart_bridge.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_uart_bridge_pkg.sv
// Shared types and constants for the UART-to-memory bridge.
package mem_uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 87;
   localparam int UART_BITS            = 10;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_DATA = 3'd1,
      WRITE    = 3'd2,
      RD_ADDR  = 3'd3,
      RD_WAIT  = 3'd4,
      SEND     = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/mem_uart_bridge_if.sv
// Bus between the bridge and its 128-byte memory (registered read data).
interface mem_uart_bridge_if;

   logic [6:0] mem_addr;
   logic       mem_wr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   modport master (output mem_addr, output mem_wr, output mem_wdata, input mem_rdata);
   modport slave  (input mem_addr, input mem_wr, input mem_wdata, output mem_rdata);

endinterface

// File: rtl/mem_uart_bridge_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, stop-bit framing check.
module uart_rx
   import mem_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_frame_err
);

   localparam logic [9:0] HALF_M1 = 10'(CLKS_PER_BIT / 2 - 1);
   localparam logic [9:0] FULL_M1 = 10'(CLKS_PER_BIT - 1);

   logic      r_sync1, r_sync2, r_prev;
   rx_state_e r_state, w_state_nx;
   logic [9:0] r_cnt, w_cnt_nx;
   logic [2:0] r_bit, w_bit_nx;
   logic [7:0] r_shift, w_shift_nx;
   logic      r_valid, w_valid_nx;
   logic      r_ferr, w_ferr_nx;

   // Synchronizer flops reset high so the idle line never looks like a start edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
         r_state <= RX_IDLE;
         r_cnt   <= 10'd0;
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync1 <= i_rx;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_bit   <= w_bit_nx;
         r_shift <= w_shift_nx;
         r_valid <= w_valid_nx;
         r_ferr  <= w_ferr_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt + 10'd1;
      w_bit_nx   = r_bit;
      w_shift_nx = r_shift;
      w_valid_nx = 1'b0;
      w_ferr_nx  = 1'b0;
      case (r_state)
         RX_IDLE: begin
            w_cnt_nx = 10'd0;
            if (r_prev && !r_sync2) w_state_nx = RX_START;
            else                    w_state_nx = RX_IDLE;
         end
         RX_START: begin
            if (r_cnt == HALF_M1) begin
               w_cnt_nx = 10'd0;
               w_bit_nx = 3'd0;
               if (r_sync2) w_state_nx = RX_IDLE;
               else         w_state_nx = RX_DATA;
            end else begin
               w_state_nx = RX_START;
            end
         end
         RX_DATA: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_nx   = 10'd0;
               w_shift_nx = {r_sync2, r_shift[7:1]};
               if (r_bit == 3'd7) w_state_nx = RX_STOP;
               else               w_bit_nx   = r_bit + 3'd1;
            end else begin
               w_state_nx = RX_DATA;
            end
         end
         RX_STOP: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_nx   = 10'd0;
               w_state_nx = RX_IDLE;
               if (r_sync2) w_valid_nx = 1'b1;
               else         w_ferr_nx  = 1'b1;
            end else begin
               w_state_nx = RX_STOP;
            end
         end
         default: begin
            w_state_nx = RX_IDLE;
            w_cnt_nx   = 10'd0;
         end
      endcase
   end

   assign o_valid     = r_valid;
   assign o_data      = r_shift;
   assign o_frame_err = r_ferr;

endmodule

// File: rtl/mem_uart_bridge.sv
// UART command bridge: {wr,addr} then data writes memory; {0,addr} reads one byte back over tx.
module mem_uart_bridge
   import mem_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic tx,
   output logic busy,
   output logic err,
   mem_uart_bridge_if.master mem
);

   localparam logic [9:0] FULL_M1 = 10'(CLKS_PER_BIT - 1);
   localparam logic [3:0] TX_LAST = 4'(UART_BITS - 1);

   logic       w_rx_valid, w_rx_ferr;
   logic [7:0] w_rx_data;
   state_e     r_state, w_state_nx;
   logic [6:0] r_mem_addr, w_mem_addr_nx;
   logic [7:0] r_mem_wdata, w_mem_wdata_nx;
   logic       r_mem_wr, r_err, w_err_nx, r_busy;
   logic       r_tx, w_tx_nx, r_tx_active, w_tx_active_nx, w_tx_start, w_tx_done;
   logic [9:0] r_tx_cnt, w_tx_cnt_nx;
   logic [3:0] r_tx_bits, w_tx_bits_nx;
   logic [8:0] r_tx_shift, w_tx_shift_nx;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rx        (rx),
      .o_valid     (w_rx_valid),
      .o_data      (w_rx_data),
      .o_frame_err (w_rx_ferr)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_mem_addr  <= 7'd0;
         r_mem_wdata <= 8'd0;
         r_mem_wr    <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_tx        <= 1'b1;
         r_tx_active <= 1'b0;
         r_tx_cnt    <= 10'd0;
         r_tx_bits   <= 4'd0;
         r_tx_shift  <= 9'd0;
      end else begin
         r_state     <= w_state_nx;
         r_mem_addr  <= w_mem_addr_nx;
         r_mem_wdata <= w_mem_wdata_nx;
         r_mem_wr    <= (w_state_nx == WRITE);
         r_err       <= w_err_nx;
         r_busy      <= (w_state_nx != IDLE) || w_tx_active_nx;
         r_tx        <= w_tx_nx;
         r_tx_active <= w_tx_active_nx;
         r_tx_cnt    <= w_tx_cnt_nx;
         r_tx_bits   <= w_tx_bits_nx;
         r_tx_shift  <= w_tx_shift_nx;
      end
   end

   assign w_tx_done = r_tx_active && (r_tx_cnt == FULL_M1) && (r_tx_bits == TX_LAST);

   // A byte arriving while a read is in flight is an overrun: dropped and flagged.
   always_comb begin
      w_state_nx     = r_state;
      w_mem_addr_nx  = r_mem_addr;
      w_mem_wdata_nx = r_mem_wdata;
      w_tx_start     = 1'b0;
      w_err_nx       = r_err | w_rx_ferr;
      case (r_state)
         IDLE: begin
            if (w_rx_valid) begin
               w_mem_addr_nx = w_rx_data[6:0];
               if (w_rx_data[7]) w_state_nx = GET_DATA;
               else              w_state_nx = RD_ADDR;
            end else begin
               w_state_nx = IDLE;
            end
         end
         GET_DATA: begin
            if (w_rx_valid) begin
               w_mem_wdata_nx = w_rx_data;
               w_state_nx     = WRITE;
            end else if (w_rx_ferr) begin
               w_state_nx = IDLE;
            end else begin
               w_state_nx = GET_DATA;
            end
         end
         WRITE:   w_state_nx = IDLE;
         RD_ADDR: begin
            w_state_nx = RD_WAIT;
            w_err_nx   = r_err | w_rx_ferr | w_rx_valid;
         end
         RD_WAIT: begin
            w_state_nx = SEND;
            w_tx_start = 1'b1;
            w_err_nx   = r_err | w_rx_ferr | w_rx_valid;
         end
         SEND: begin
            if (w_tx_done) w_state_nx = IDLE;
            else           w_state_nx = SEND;
            w_err_nx = r_err | w_rx_ferr | w_rx_valid;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // Transmitter: r_tx_bits is the frame slot on the line (0 start, 1..8 data, 9 stop).
   always_comb begin
      w_tx_nx        = r_tx;
      w_tx_active_nx = r_tx_active;
      w_tx_cnt_nx    = r_tx_cnt;
      w_tx_bits_nx   = r_tx_bits;
      w_tx_shift_nx  = r_tx_shift;
      if (w_tx_start) begin
         w_tx_nx        = 1'b0;
         w_tx_active_nx = 1'b1;
         w_tx_cnt_nx    = 10'd0;
         w_tx_bits_nx   = 4'd0;
         w_tx_shift_nx  = {1'b1, mem.mem_rdata};
      end else if (r_tx_active) begin
         if (r_tx_cnt == FULL_M1) begin
            w_tx_cnt_nx = 10'd0;
            if (r_tx_bits == TX_LAST) begin
               w_tx_active_nx = 1'b0;
               w_tx_nx        = 1'b1;
            end else begin
               w_tx_nx       = r_tx_shift[0];
               w_tx_shift_nx = {1'b1, r_tx_shift[8:1]};
               w_tx_bits_nx  = r_tx_bits + 4'd1;
            end
         end else begin
            w_tx_cnt_nx = r_tx_cnt + 10'd1;
         end
      end else begin
         w_tx_nx = 1'b1;
      end
   end

   assign tx            = r_tx;
   assign busy          = r_busy;
   assign err           = r_err;
   assign mem.mem_addr  = r_mem_addr;
   assign mem.mem_wr    = r_mem_wr;
   assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_uart_bridge.sv
// Directed + random bench for mem_uart_bridge against a reference memory image and a tx frame decoder.
module tb_mem_uart_bridge;
   import mem_uart_pkg::*;

   localparam int CPB = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   logic tx, busy, err;

   mem_uart_bridge_if mbus ();

   mem_uart_bridge #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .tx    (tx),
      .busy  (busy),
      .err   (err),
      .mem   (mbus)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem_arr [128];
   logic [7:0]  ref_mem [128];
   logic [14:0] wr_log [$];
   logic [9:0]  frames [$];
   int tx_low_cnt = 0;
   int n_assert = 0;
   int n_fail = 0;
   int n_wr_exp = 0;

   // Memory with one-cycle registered read latency
   always @(posedge clk) begin
      if (mbus.mem_wr === 1'b1) mem_arr[mbus.mem_addr] <= mbus.mem_wdata;
      mbus.mem_rdata <= mem_arr[mbus.mem_addr];
   end

   always @(negedge clk) begin
      if (mbus.mem_wr === 1'b1) wr_log.push_back({mbus.mem_addr, mbus.mem_wdata});
      if (tx === 1'b0) tx_low_cnt++;
   end

   // Decodes tx frames by mid-bit sampling; a frame cut by reset is discarded.
   initial begin : tx_decoder
      logic [9:0] f;
      logic [3:0] k;
      bit aborted;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            aborted = 1'b0;
            f = '1;
            for (int c = 0; c < CPB/2 + 9*CPB; c++) begin
               @(negedge clk);
               if (rst_n !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               if (c >= CPB/2 - 1 && ((c - (CPB/2 - 1)) % CPB) == 0) begin
                  k = 4'((c - (CPB/2 - 1)) / CPB);
                  f[k] = tx;
               end
            end
            if (!aborted) frames.push_back(f);
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop_v;
      tick(CPB);
      rx = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 300) begin
         tick(1);
         n++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d);
      int low0;
      logic [14:0] last;
      low0 = tx_low_cnt;
      send_byte({1'b1, a}, 1'b1);
      send_byte(d, 1'b1);
      tick(4);
      ref_mem[a] = d;
      n_wr_exp++;
      last = (wr_log.size() > 0) ? wr_log[wr_log.size()-1] : 'x;
      check("wr_count", 32'(wr_log.size()), 32'(n_wr_exp));
      check("wr_entry", 32'(last), 32'({a, d}));
      check("wr_tx_quiet", 32'(tx_low_cnt), 32'(low0));
      check("wr_idle", 32'(busy), 32'd0);
   endtask

   task automatic wait_frame(input string tag, input logic [7:0] exp_byte);
      int n;
      logic [9:0] f;
      n = 0;
      while (frames.size() == 0 && n < 400) begin
         tick(1);
         n++;
      end
      f = (frames.size() > 0) ? frames.pop_front() : 'x;
      check(tag, 32'(f), 32'({1'b1, exp_byte, 1'b0}));
   endtask

   task automatic do_read(input logic [6:0] a);
      send_byte({1'b0, a}, 1'b1);
      wait_frame("rd_frame", ref_mem[a]);
      wait_idle("rd_idle");
      check("rd_no_write", 32'(wr_log.size()), 32'(n_wr_exp));
      tick(2);
   endtask

   initial begin : main
      int n;
      int low0;
      int nwr0;
      logic [6:0] a;
      logic [7:0] d;
      for (int i = 0; i < 128; i++) begin
         mem_arr[i] = 8'((i * 29 + 7) ^ (i >> 2));
         ref_mem[i] = 8'((i * 29 + 7) ^ (i >> 2));
      end
      rst_n = 1'b0;
      rx = 1'b1;
      tick(3);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_mem_wr", 32'(mbus.mem_wr), 32'd0);
      check("rst_mem_addr", 32'(mbus.mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mbus.mem_wdata), 32'd0);
      rst_n = 1'b1;
      tick(5);

      // Basic write 0x05 <- 0x3C
      do_write(7'h05, 8'h3C);

      // Write 0x7F <- 0xA5 and read it back; busy must drop right after the stop bit
      do_write(7'h7F, 8'hA5);
      send_byte(8'h7F, 1'b1);
      wait_frame("rd7f_frame", 8'hA5);
      check("rd7f_busy_in_stop", 32'(busy), 32'd1);
      n = 0;
      while (busy !== 1'b0 && n < 20) begin
         tick(1);
         n++;
      end
      check("rd7f_busy_fall", 32'(n >= 1 && n <= CPB/2), 32'd1);
      check("rd7f_tx_idle", 32'(tx), 32'd1);
      tick(4);

      // Random mix of writes and reads
      for (int i = 0; i < 16; i++) begin
         a = 7'($urandom_range(0, 127));
         d = 8'($urandom);
         if ($urandom_range(0, 1) == 1) do_write(a, d);
         else                           do_read(a);
      end
      check("rand_err_clear", 32'(err), 32'd0);

      // Framing error on a would-be write command
      nwr0 = wr_log.size();
      send_byte(8'h90, 1'b0);
      tick(10);
      check("ferr_err", 32'(err), 32'd1);
      check("ferr_busy", 32'(busy), 32'd0);
      check("ferr_no_write", 32'(wr_log.size()), 32'(nwr0));
      do_write(7'($urandom_range(0, 127)), 8'($urandom));

      // Reset, then a 2-cycle glitch must be a false start
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(4);
      check("rst2_err", 32'(err), 32'd0);
      low0 = tx_low_cnt;
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(40);
      check("glitch_err", 32'(err), 32'd0);
      check("glitch_busy", 32'(busy), 32'd0);
      check("glitch_tx", 32'(tx_low_cnt), 32'(low0));
      check("glitch_no_write", 32'(wr_log.size()), 32'(n_wr_exp));

      // Read 0x00 with a second byte arriving during the response
      send_byte(8'h00, 1'b1);
      send_byte(8'h81, 1'b1);
      wait_frame("ovr_frame", ref_mem[0]);
      wait_idle("ovr_idle");
      tick(20);
      check("ovr_err", 32'(err), 32'd1);
      check("ovr_dropped", 32'(busy), 32'd0);
      check("ovr_no_write", 32'(wr_log.size()), 32'(n_wr_exp));

      // Reset in the middle of a response frame
      a = 7'($urandom_range(1, 127));
      send_byte({1'b0, a}, 1'b1);
      n = 0;
      while (tx !== 1'b0 && n < 300) begin
         tick(1);
         n++;
      end
      check("mid_tx_started", 32'(tx), 32'd0);
      tick(30);
      rst_n = 1'b0;
      tick(1);
      check("mid_rst_tx", 32'(tx), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      check("mid_rst_addr", 32'(mbus.mem_addr), 32'd0);
      tick(3);
      rst_n = 1'b1;
      tick(5);
      check("mid_rst_no_frame", 32'(frames.size()), 32'd0);
      check("mid_rst_no_write", 32'(wr_log.size()), 32'(n_wr_exp));
      do_read(a);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
